// File: rtl/fft_pkg.sv
// Shared FFT datapath types and fixed-point helpers (rounding, saturation).
package fft_pkg;

    localparam int unsigned FFT_DATA_WIDTH = 16;
    localparam int unsigned CALC_WIDTH     = 64;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
    } complex_t;

    typedef logic signed [CALC_WIDTH-1:0] calc_t;

    // Clamp a wide signed value into the range of a width-bit signed number.
    function automatic calc_t sat_fn(input calc_t value, input int unsigned width);
        calc_t max_v;
        calc_t min_v;
        calc_t res;
        max_v = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
        min_v = -max_v - calc_t'(1);
        if (value > max_v) begin
            res = max_v;
        end else if (value < min_v) begin
            res = min_v;
        end else begin
            res = value;
        end
        return res;
    endfunction

    // Round half-up, then arithmetic shift right; sh == 0 passes the value through.
    function automatic calc_t round_shift_fn(input calc_t value, input int unsigned sh);
        calc_t res;
        if (sh == 0) begin
            res = value;
        end else begin
            res = (value + (calc_t'(1) <<< (sh - 1))) >>> sh;
        end
        return res;
    endfunction

endpackage

// File: rtl/butterfly2_dif_pipe_if.sv
// Elastic input/output bus of the DIF butterfly; master drives inputs, slave is the butterfly.
interface butterfly2_dif_pipe_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                         in_valid_i;
    logic                         in_ready_o;
    logic                         inv_i;
    logic signed [DATA_WIDTH-1:0] a_re_i;
    logic signed [DATA_WIDTH-1:0] a_im_i;
    logic signed [DATA_WIDTH-1:0] b_re_i;
    logic signed [DATA_WIDTH-1:0] b_im_i;
    logic signed [DATA_WIDTH-1:0] coeff_re_i;
    logic signed [DATA_WIDTH-1:0] coeff_im_i;
    logic                         out_valid_o;
    logic                         out_ready_i;
    logic signed [DATA_WIDTH-1:0] c_re_o;
    logic signed [DATA_WIDTH-1:0] c_im_o;
    logic signed [DATA_WIDTH-1:0] d_re_o;
    logic signed [DATA_WIDTH-1:0] d_im_o;
    logic                         ovf_o;

    modport master (
        output in_valid_i, inv_i, a_re_i, a_im_i, b_re_i, b_im_i, coeff_re_i, coeff_im_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, c_re_o, c_im_o, d_re_o, d_im_o, ovf_o
    );

    modport slave (
        input  in_valid_i, inv_i, a_re_i, a_im_i, b_re_i, b_im_i, coeff_re_i, coeff_im_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, c_re_o, c_im_o, d_re_o, d_im_o, ovf_o
    );
endinterface

// File: rtl/butterfly2_dif_pipe_cmult.sv
// Registered full-precision complex multiplier with load enable; no rounding.
module cmult_pipe #(
    parameter int unsigned X_WIDTH = 17,
    parameter int unsigned W_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic signed [X_WIDTH-1:0]      x_re_i,
    input  logic signed [X_WIDTH-1:0]      x_im_i,
    input  logic signed [W_WIDTH-1:0]      w_re_i,
    input  logic signed [W_WIDTH-1:0]      w_im_i,
    output logic signed [X_WIDTH+W_WIDTH:0] p_re_o,
    output logic signed [X_WIDTH+W_WIDTH:0] p_im_o
);
    localparam int unsigned P_WIDTH = X_WIDTH + W_WIDTH + 1;

    logic signed [P_WIDTH-1:0] p_re_d, p_re_q;
    logic signed [P_WIDTH-1:0] p_im_d, p_im_q;

    always_comb begin
        p_re_d = p_re_q;
        p_im_d = p_im_q;
        if (en_i) begin
            p_re_d = P_WIDTH'(x_re_i) * P_WIDTH'(w_re_i) - P_WIDTH'(x_im_i) * P_WIDTH'(w_im_i);
            p_im_d = P_WIDTH'(x_re_i) * P_WIDTH'(w_im_i) + P_WIDTH'(x_im_i) * P_WIDTH'(w_re_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_re_q <= '0;
            p_im_q <= '0;
        end else begin
            p_re_q <= p_re_d;
            p_im_q <= p_im_d;
        end
    end

    assign p_re_o = p_re_q;
    assign p_im_o = p_im_q;

endmodule

// File: rtl/butterfly2_dif_pipe.sv
// Three-stage radix-2 DIF butterfly: c = (a+b)>>SCALE, d = ((a-b)*W)>>SCALE, elastic handshakes.
module butterfly2_dif_pipe
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SCALE      = 1
) (
    input logic               clk_i,
    input logic               rst_ni,
    butterfly2_dif_pipe_if.slave bus
);
    localparam int unsigned SUM_W   = DATA_WIDTH + 1;
    localparam int unsigned PROD_W  = 2 * DATA_WIDTH + 2;
    localparam int unsigned D_SHIFT = DATA_WIDTH - 1 + SCALE;
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic s1_en_c, s2_en_c, s3_en_c, in_fire_c, mult_en_c;

    logic                    s1_valid_d, s1_valid_q;
    logic signed [SUM_W-1:0] s1_sum_re_d, s1_sum_re_q, s1_sum_im_d, s1_sum_im_q;
    logic signed [SUM_W-1:0] s1_diff_re_d, s1_diff_re_q, s1_diff_im_d, s1_diff_im_q;
    logic signed [DATA_WIDTH-1:0] s1_w_re_d, s1_w_re_q, s1_w_im_d, s1_w_im_q;

    logic                    s2_valid_d, s2_valid_q;
    logic signed [SUM_W-1:0] s2_sum_re_d, s2_sum_re_q, s2_sum_im_d, s2_sum_im_q;
    logic signed [PROD_W-1:0] s2_p_re, s2_p_im;

    logic                         s3_valid_d, s3_valid_q;
    logic signed [DATA_WIDTH-1:0] c_re_d, c_re_q, c_im_d, c_im_q;
    logic signed [DATA_WIDTH-1:0] d_re_d, d_re_q, d_im_d, d_im_q;
    logic                         ovf_d, ovf_q;

    calc_t c_re_r, c_im_r, d_re_r, d_im_r;
    calc_t c_re_s, c_im_s, d_re_s, d_im_s;

    // A stage loads when empty or when its contents move on this cycle.
    always_comb begin
        s3_en_c   = !s3_valid_q || bus.out_ready_i;
        s2_en_c   = !s2_valid_q || s3_en_c;
        s1_en_c   = !s1_valid_q || s2_en_c;
        in_fire_c = bus.in_valid_i && rst_ni && s1_en_c;
        mult_en_c = s2_en_c && s1_valid_q;
    end

    assign bus.in_ready_o = rst_ni && s1_en_c;

    // S1: exact sum/difference and effective (optionally conjugated) twiddle.
    always_comb begin
        s1_valid_d   = s1_en_c ? in_fire_c : s1_valid_q;
        s1_sum_re_d  = s1_sum_re_q;
        s1_sum_im_d  = s1_sum_im_q;
        s1_diff_re_d = s1_diff_re_q;
        s1_diff_im_d = s1_diff_im_q;
        s1_w_re_d    = s1_w_re_q;
        s1_w_im_d    = s1_w_im_q;
        if (in_fire_c) begin
            s1_sum_re_d  = SUM_W'(bus.a_re_i) + SUM_W'(bus.b_re_i);
            s1_sum_im_d  = SUM_W'(bus.a_im_i) + SUM_W'(bus.b_im_i);
            s1_diff_re_d = SUM_W'(bus.a_re_i) - SUM_W'(bus.b_re_i);
            s1_diff_im_d = SUM_W'(bus.a_im_i) - SUM_W'(bus.b_im_i);
            s1_w_re_d    = bus.coeff_re_i;
            if (!bus.inv_i) begin
                s1_w_im_d = bus.coeff_im_i;
            end else if (bus.coeff_im_i == MIN_VAL) begin
                s1_w_im_d = MAX_VAL;
            end else begin
                s1_w_im_d = -bus.coeff_im_i;
            end
        end
    end

    // S2: product lives in the multiplier; the sum and valid ride alongside.
    cmult_pipe #(
        .X_WIDTH(SUM_W),
        .W_WIDTH(DATA_WIDTH)
    ) u_cmult (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (mult_en_c),
        .x_re_i (s1_diff_re_q),
        .x_im_i (s1_diff_im_q),
        .w_re_i (s1_w_re_q),
        .w_im_i (s1_w_im_q),
        .p_re_o (s2_p_re),
        .p_im_o (s2_p_im)
    );

    always_comb begin
        s2_valid_d  = s2_en_c ? s1_valid_q : s2_valid_q;
        s2_sum_re_d = s2_sum_re_q;
        s2_sum_im_d = s2_sum_im_q;
        if (mult_en_c) begin
            s2_sum_re_d = s1_sum_re_q;
            s2_sum_im_d = s1_sum_im_q;
        end
    end

    // S3: round, saturate and flag any clipping for this transaction.
    always_comb begin
        s3_valid_d = s3_en_c ? s2_valid_q : s3_valid_q;
        c_re_d     = c_re_q;
        c_im_d     = c_im_q;
        d_re_d     = d_re_q;
        d_im_d     = d_im_q;
        ovf_d      = ovf_q;
        c_re_r     = round_shift_fn(calc_t'(s2_sum_re_q), SCALE);
        c_im_r     = round_shift_fn(calc_t'(s2_sum_im_q), SCALE);
        d_re_r     = round_shift_fn(calc_t'(s2_p_re), D_SHIFT);
        d_im_r     = round_shift_fn(calc_t'(s2_p_im), D_SHIFT);
        c_re_s     = sat_fn(c_re_r, DATA_WIDTH);
        c_im_s     = sat_fn(c_im_r, DATA_WIDTH);
        d_re_s     = sat_fn(d_re_r, DATA_WIDTH);
        d_im_s     = sat_fn(d_im_r, DATA_WIDTH);
        if (s3_en_c && s2_valid_q) begin
            c_re_d = DATA_WIDTH'(c_re_s);
            c_im_d = DATA_WIDTH'(c_im_s);
            d_re_d = DATA_WIDTH'(d_re_s);
            d_im_d = DATA_WIDTH'(d_im_s);
            ovf_d  = (c_re_s != c_re_r) || (c_im_s != c_im_r) ||
                     (d_re_s != d_re_r) || (d_im_s != d_im_r);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q   <= 1'b0;
            s1_sum_re_q  <= '0;
            s1_sum_im_q  <= '0;
            s1_diff_re_q <= '0;
            s1_diff_im_q <= '0;
            s1_w_re_q    <= '0;
            s1_w_im_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_sum_re_q  <= '0;
            s2_sum_im_q  <= '0;
            s3_valid_q   <= 1'b0;
            c_re_q       <= '0;
            c_im_q       <= '0;
            d_re_q       <= '0;
            d_im_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sum_re_q  <= s1_sum_re_d;
            s1_sum_im_q  <= s1_sum_im_d;
            s1_diff_re_q <= s1_diff_re_d;
            s1_diff_im_q <= s1_diff_im_d;
            s1_w_re_q    <= s1_w_re_d;
            s1_w_im_q    <= s1_w_im_d;
            s2_valid_q   <= s2_valid_d;
            s2_sum_re_q  <= s2_sum_re_d;
            s2_sum_im_q  <= s2_sum_im_d;
            s3_valid_q   <= s3_valid_d;
            c_re_q       <= c_re_d;
            c_im_q       <= c_im_d;
            d_re_q       <= d_re_d;
            d_im_q       <= d_im_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.out_valid_o = s3_valid_q;
    assign bus.c_re_o      = c_re_q;
    assign bus.c_im_o      = c_im_q;
    assign bus.d_re_o      = d_re_q;
    assign bus.d_im_o      = d_im_q;
    assign bus.ovf_o       = ovf_q;

endmodule

// File: tb/tb_butterfly2_dif_pipe.sv
// Bench for butterfly2_dif_pipe: arithmetic reference model + scoreboard, directed and random traffic.
module tb_butterfly2_dif_pipe;
    localparam int unsigned DW = 16;
    localparam int unsigned SC = 1;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;

    butterfly2_dif_pipe_if #(.DATA_WIDTH(DW)) bus ();

    butterfly2_dif_pipe #(.DATA_WIDTH(DW), .SCALE(SC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint c_re;
        longint c_im;
        longint d_re;
        longint d_im;
        longint ovf;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    exp_t   pin_e;
    int     n_cmp = 0;
    int     n_err = 0;
    int     n_in  = 0;
    int     n_out = 0;
    int     ready_mode = 1;
    bit     hold_v = 1'b0;
    logic signed [DW-1:0] h_c_re, h_c_im, h_d_re, h_d_im;
    logic   h_ovf;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint clip(input longint v);
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -hi - 1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // floor((x + 2^(sh-1)) / 2^sh), i.e. round half toward +inf
    function automatic longint rnd(input longint x, input int sh);
        if (sh == 0) return x;
        return (x + (longint'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic exp_t model(input longint ar, ai, br, bi, wr, wi, input bit inv);
        exp_t e;
        longint w_i, dr, di, pr, pim, cr, ci, r_dr, r_di;
        w_i = inv ? clip(-wi) : wi;
        dr  = ar - br;
        di  = ai - bi;
        pr  = dr * wr - di * w_i;
        pim = dr * w_i + di * wr;
        cr   = rnd(ar + br, SC);
        ci   = rnd(ai + bi, SC);
        r_dr = rnd(pr, DW - 1 + SC);
        r_di = rnd(pim, DW - 1 + SC);
        e.c_re = clip(cr);
        e.c_im = clip(ci);
        e.d_re = clip(r_dr);
        e.d_im = clip(r_di);
        e.ovf  = ((e.c_re != cr) || (e.c_im != ci) || (e.d_re != r_dr) || (e.d_im != r_di)) ? 1 : 0;
        return e;
    endfunction

    // Scoreboard: all sampling on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_ni) begin
            exp_q.delete();
            hold_v = 1'b0;
            chk("rst_in_ready", longint'(bus.in_ready_o), 0);
            chk("rst_out_valid", longint'(bus.out_valid_o), 0);
        end else begin
            if (hold_v) begin
                chk("hold_valid", longint'(bus.out_valid_o), 1);
                chk("hold_c_re", bus.c_re_o, h_c_re);
                chk("hold_c_im", bus.c_im_o, h_c_im);
                chk("hold_d_re", bus.d_re_o, h_d_re);
                chk("hold_d_im", bus.d_im_o, h_d_im);
                chk("hold_ovf", longint'(bus.ovf_o), longint'(h_ovf));
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", exp_q.size(), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_c_re", bus.c_re_o, mon_e.c_re);
                    chk("out_c_im", bus.c_im_o, mon_e.c_im);
                    chk("out_d_re", bus.d_re_o, mon_e.d_re);
                    chk("out_d_im", bus.d_im_o, mon_e.d_im);
                    chk("out_ovf", longint'(bus.ovf_o), mon_e.ovf);
                end
                n_out++;
            end
            hold_v = bus.out_valid_o && !bus.out_ready_i;
            h_c_re = bus.c_re_o;
            h_c_im = bus.c_im_o;
            h_d_re = bus.d_re_o;
            h_d_im = bus.d_im_o;
            h_ovf  = bus.ovf_o;
            if (bus.in_valid_i && bus.in_ready_o) begin
                exp_q.push_back(model(bus.a_re_i, bus.a_im_i, bus.b_re_i, bus.b_im_i,
                                      bus.coeff_re_i, bus.coeff_im_i, bus.inv_i));
                n_in++;
            end
        end
    end

    initial begin
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready_i = 1'b0;
                1:       bus.out_ready_i = 1'b1;
                default: bus.out_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic drive(input int ar, ai, br, bi, wr, wi, input bit inv);
        bit acc = 1'b0;
        int n = 0;
        bus.a_re_i     = DW'(ar);
        bus.a_im_i     = DW'(ai);
        bus.b_re_i     = DW'(br);
        bus.b_im_i     = DW'(bi);
        bus.coeff_re_i = DW'(wr);
        bus.coeff_im_i = DW'(wi);
        bus.inv_i      = inv;
        bus.in_valid_i = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", longint'(acc), 1);
        bus.in_valid_i = 1'b0;
    endtask

    task automatic directed(input string nm, input int ar, ai, br, bi, wr, wi, input bit inv,
                            input int ec_re, ec_im, ed_re, ed_im, eovf);
        int n = 0;
        drive(ar, ai, br, bi, wr, wi, inv);
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid_o && n < 20);
        chk({nm, "_latency"}, n, 3);
        chk({nm, "_c_re"}, bus.c_re_o, ec_re);
        chk({nm, "_c_im"}, bus.c_im_o, ec_im);
        chk({nm, "_d_re"}, bus.d_re_o, ed_re);
        chk({nm, "_d_im"}, bus.d_im_o, ed_im);
        chk({nm, "_ovf"}, longint'(bus.ovf_o), eovf);
        @(posedge clk);
        #1;
    endtask

    function automatic int rval();
        case ($urandom_range(0, 7))
            0:       return 32767;
            1:       return -32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_in=%0d expected end", n_in);
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        int n;
        bus.in_valid_i = 1'b0;
        bus.inv_i = 1'b0;
        bus.a_re_i = '0; bus.a_im_i = '0; bus.b_re_i = '0; bus.b_im_i = '0;
        bus.coeff_re_i = '0; bus.coeff_im_i = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ovf", longint'(bus.ovf_o), 0);
        chk("reset_c_re", bus.c_re_o, 0);
        chk("reset_c_im", bus.c_im_o, 0);
        chk("reset_d_re", bus.d_re_o, 0);
        chk("reset_d_im", bus.d_im_o, 0);

        // Hand-computed pins for the reference model itself
        pin_e = model(32767, 32767, -32768, -32768, -32768, -32768, 1'b0);
        chk("model_sat_d_im", pin_e.d_im, -32768);
        chk("model_sat_ovf", pin_e.ovf, 1);
        pin_e = model(1000, 2000, 200, -400, 0, -32768, 1'b1);
        chk("model_inv_d_re", pin_e.d_re, -1200);
        chk("model_inv_d_im", pin_e.d_im, 400);

        @(posedge clk); #1;
        rst_ni = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Directed vectors with literal expectations
        directed("t1", 1000, 2000, 200, -400, 32767, 0, 1'b0, 600, 800, 400, 1200, 0);
        directed("t2", 1000, 2000, 200, -400, 0, -32768, 1'b0, 600, 800, 1200, -400, 0);
        directed("t2inv", 1000, 2000, 200, -400, 0, -32768, 1'b1, 600, 800, -1200, 400, 0);
        directed("t3sat", 32767, 32767, -32768, -32768, -32768, -32768, 1'b0, 0, 0, 0, -32768, 1);
        directed("t3next", 1000, 2000, 200, -400, 32767, 0, 1'b0, 600, 800, 400, 1200, 0);

        // Backpressure: three fill the pipe, two more wait for the drain
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        snap = n_out;
        drive(100, -100, 50, 25, 16384, 0, 1'b0);
        drive(-3000, 4000, 1000, -1000, 0, 16384, 1'b0);
        drive(7, 9, -7, -9, 23170, -23170, 1'b1);
        @(negedge clk);
        chk("bp_in_ready_low", longint'(bus.in_ready_o), 0);
        chk("bp_out_valid", longint'(bus.out_valid_o), 1);
        repeat (4) @(negedge clk);
        fork
            begin
                drive(32767, -32768, -32768, 32767, 32767, 32767, 1'b0);
                drive(-1, 1, 1, -1, -32768, 0, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                ready_mode = 1;
            end
        join
        repeat (10) begin @(posedge clk); #1; end
        chk("bp_outputs", n_out - snap, 5);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Random traffic with random downstream readiness
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            drive(rval(), rval(), rval(), rval(), rval(), rval(), 1'($urandom_range(0, 1)));
        end
        ready_mode = 1;
        repeat (10) begin @(posedge clk); #1; end
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_in_eq_out", n_in, n_out);

        // Reset with two transactions in flight
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        drive(500, 600, 100, 200, 32767, 0, 1'b0);
        drive(-500, -600, 100, 200, 0, 32767, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_out_valid", longint'(bus.out_valid_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_now_out_valid", longint'(bus.out_valid_o), 0);
        chk("rst_now_in_ready", longint'(bus.in_ready_o), 0);
        repeat (2) begin @(posedge clk); #1; end
        ready_mode = 1;
        rst_ni = 1'b1;
        snap = n_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle", longint'(bus.out_valid_o), 0);
        end
        @(posedge clk); #1;
        directed("post_rst", 1000, 2000, 200, -400, 32767, 0, 1'b0, 600, 800, 400, 1200, 0);
        repeat (6) begin @(posedge clk); #1; end
        chk("post_rst_one_out", n_out - snap, 1);
        chk("post_rst_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/butterfly2_dif_pipe.md
Name: butterfly2_dif_pipe

Overview:
Pipelined radix-2 decimation-in-frequency butterfly, the inverse-direction counterpart to the existing combinational DIT butterfly. It computes c = (a+b)·2^-SCALE and d = ((a-b)·W)·2^-SCALE, with optional twiddle conjugation for IFFT use. It uses elastic valid/ready handshakes on input and output, so it can sit between a sample/twiddle fetch unit and the FFT working-memory writeback. All data is signed two's complement; the twiddle is Q1.(DATA_WIDTH-1).

Parameters:
DATA_WIDTH, 16, width of each real/imag component, signed.
SCALE, 1, 0 or 1; extra right shift applied to both outputs (per-stage 1/2 scaling).

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
in_valid_i  in  1  input transaction valid
in_ready_o  out  1  block accepts input this cycle
inv_i  in  1  conjugate twiddle (IFFT mode), sampled with the input
a_re_i, a_im_i  in  DATA_WIDTH each  operand a
b_re_i, b_im_i  in  DATA_WIDTH each  operand b
coeff_re_i, coeff_im_i  in  DATA_WIDTH each  twiddle W, Q1.(DATA_WIDTH-1)
out_valid_o  out  1  output transaction valid
out_ready_i  in  1  downstream accepts output
c_re_o, c_im_o  out  DATA_WIDTH each  sum output
d_re_o, d_im_o  out  DATA_WIDTH each  twiddled difference output
ovf_o  out  1  saturation occurred in this output transaction; qualified by out_valid_o

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all stage valids are 0, out_valid_o=0, ovf_o=0, and all data outputs are 0. in_ready_o is forced to 0 while rst_ni=0.
- Transfers: an input transfer occurs when in_valid_i && in_ready_o; an output transfer occurs when out_valid_o && out_ready_i.
- Pipeline has three register stages, S1→S2→S3. S3 drives the outputs directly from registers.
- Stage advance: stage k loads when it is empty or its contents move on this cycle. in_ready_o = rst_ni && (!S1.valid || S1 advances). This path is combinational from out_ready_i.
- Latency and throughput: latency is 3 cycles from input transfer to out_valid_o with out_ready_i held high. Throughput is 1 transaction per cycle. Up to 3 transactions may be in flight.
- Ordering: outputs are in order. No transaction is dropped or duplicated under any out_ready_i pattern.
- Output stability: while out_valid_o=1 and out_ready_i=0, all outputs hold stable.
- S1: sum = a+b and diff = a-b per component, each DATA_WIDTH+1 bits, no truncation. The effective twiddle is registered here. When inv_i=1, w_im = -coeff_im, and negation of the most-negative value saturates to max positive.
- S2: full-precision complex product, 2·DATA_WIDTH+2 bits:
  - p_re = diff_re·w_re - diff_im·w_im
  - p_im = diff_re·w_im + diff_im·w_re
  - sum is carried alongside.
- S3 d outputs: shift sh = DATA_WIDTH-1+SCALE, round half-up (add 2^(sh-1), then arithmetic shift right by sh), then saturate to DATA_WIDTH signed.
- S3 c outputs: if SCALE=1, round half-up by 1 bit. Saturate to DATA_WIDTH in both cases.
- ovf_o = OR of the four saturation events for that transaction.
- Reset mid-operation: all in-flight transactions are discarded immediately. After release, the first out_valid_o is no earlier than 3 cycles after the next input transfer.
- Twiddle range: coeff +1.0 is not representable (0x7FFF ≈ 1), and -1.0 (0x8000) is exact. No special-casing beyond the rules above.

Decomposition:
- Shared package fft_pkg holds:
  - complex_t struct {re, im} parameterised by DATA_WIDTH via localparam default 16
  - functions sat_fn(value, width) and round_shift_fn(value, sh)
- One sub-module: cmult_pipe. It is a registered complex multiplier (S2) with enable, full-precision output and no rounding. It is kept separate so it can be reused by a future radix-4 block.
- S1 and S3 stay in butterfly2_dif_pipe.

Test Plan:
1. W=16, SCALE=1, out_ready=1. Input a=(1000,2000), b=(200,-400), W=(0x7FFF,0), inv=0 -> 3 cycles later c=(600,800), d=(400,1200), ovf=0.
2. Same a, b, W=(0x0000,0x8000) (-j), inv=0 -> c=(600,800), d=(1200,-400). The same input with inv=1 gives w_im=0x7FFF -> d=(-1200,400).
3. Saturation: a=(0x7FFF,0x7FFF), b=(0x8000,0x8000), W=(0x8000,0x8000) -> c=(0,0), d=(0,0x8000), ovf=1. The next transaction, case 1, gives ovf=0.
4. Backpressure: issue 5 back-to-back inputs with out_ready=0 -> in_ready_o drops after 3 accepted and out_valid_o=1 with outputs stable. Then out_ready=1 -> all 5 outputs emerge in order, one per cycle, none lost.
5. Random out_ready toggling with 1000 random vectors -> outputs match the bit-exact reference model (rounding and saturation) in order.
6. Reset mid-operation: assert rst_ni=0 with 2 transactions in flight -> out_valid_o=0 and in_ready_o=0 immediately. After release, a single input yields exactly one output 3 cycles later.
